trng_arbiter: RTL
=================

# trng_arbiter

- Shares one TRNG word source between `NUM_REQ` key-material consumers, such as ChaCha20 cores acquiring key, nonce and counter words.
- Each consumer sees the standard request/ready word handshake.
- Arbitration is round-robin with a burst lock, so a core's 12-word acquisition stays contiguous; `BURST_MAX` bounds the lock when others are waiting.
- Sits between the TRNG and the crypto cores; owns the TRNG-side handshake and timeout.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `DATA_W`, 32: word width.
- `BURST_MAX`, 12: words per grant before forced release, if another requester is pending.
- `TIMEOUT`, 1024: max cycles waiting for `src_ready`; 0 disables the timeout.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_REQ`: per-requester level request for one word at a time.
- `req_ready` out `NUM_REQ`: one-hot, 1-cycle pulse; `req_data` is valid for the granted requester.
- `req_data` out `DATA_W`: shared word bus, registered.
- `grant` out `NUM_REQ`: one-hot current owner, 0 when idle.
- `src_request` out 1: level request to the TRNG.
- `src_ready` in 1: 1-cycle pulse, `src_data` valid.
- `src_data` in `DATA_W`: TRNG word.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: sticky; cleared only by `rst`.

## Operation
- The FSM has four states: IDLE, FETCH, DELIVER and CHECK.
- **Reset.** All outputs go to 0, `req_data` goes to 0 and the state goes to IDLE.
  - Round-robin pointer `ptr` is set to `NUM_REQ-1`, so requester 0 wins first.
  - `word_cnt` is set to 0.
- **IDLE.** If any `req` bit is high, choose the first set bit scanning from `ptr+1` upward with wrap-around.
  - Load `grant`, clear `word_cnt`, go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH.** `src_request` = 1.
  - On `src_ready`: capture `src_data` into `req_data`, increment `word_cnt`, clear the timeout counter, go to DELIVER.
  - Each cycle without `src_ready` increments the timeout counter.
  - If `TIMEOUT`≠0 and the count reaches `TIMEOUT`: set `timeout_err`, set `ptr` = owner, clear `grant`, go to IDLE.
- **DELIVER.** `req_ready[owner]` = 1 for exactly this cycle; `src_request` = 0.
  - The word is delivered even if the owner's `req` dropped while it was fetched.
  - Go to CHECK.
- **CHECK.** Sample `req[owner]`.
  - If low: release.
  - Else if `word_cnt` == `BURST_MAX` and any other `req` bit is high: release.
  - Else: go to FETCH. If `word_cnt` == `BURST_MAX` with no competitor, clear `word_cnt` and keep the grant.
  - Release means: `ptr` = owner, `grant` = 0, go to IDLE.
- **Word counting.** `word_cnt` width is `$clog2(BURST_MAX+1)` and it never wraps past `BURST_MAX`.
- **Ignored inputs.**
  - `src_ready` outside FETCH is ignored and its data discarded.
  - `req` changes during FETCH and DELIVER do not change the owner.
- **Invariant.** At most one TRNG word is outstanding at any time.
- **Reset mid-operation.** A reset in any state returns to the reset condition at that edge; an in-flight word is discarded.

## Timing
- **Grant latency.** `req` high at edge E0 in IDLE → `grant` and `src_request` are high from E0 onward (FETCH).
- **Word latency.**
  - `src_ready` sampled at edge E1 → `req_ready` and `req_data` valid for the cycle after E1.
  - CHECK follows at E1+1.
  - FETCH is re-entered at E1+2.
- **Throughput.** Best case is one word per 3 cycles, with `src_ready` asserted on the first FETCH cycle.
- **Requester rule.** A requester wanting no further word must drop `req` no later than the DELIVER cycle, i.e. be low at the CHECK edge.
- **Handover.** From the release decision at the CHECK edge to the next owner's `grant`: 2 edges (CHECK→IDLE→FETCH).
- **Output timing.** `req_ready`, `src_request`, `grant` and `busy` are decoded from registered state, with no input-to-output combinational path.

## Test plan
1. **Single requester, full acquisition.**
   - Stimulus: `req[0]` held high; TRNG answers 2 cycles after `src_request` with words 0x00000001..0x0000000C; `req[0]` dropped after the 12th `req_ready`.
   - Required: 12 `req_ready[0]` pulses carrying words in order; `grant` = 01 throughout; then IDLE with `busy` = 0.
2. **Simultaneous request and burst limit.**
   - Stimulus: `req[0]` and `req[1]` rise at the same edge after reset; `req[0]` wants 20 words.
   - Required: requester 0 gets words 1–12; `grant` switches to 10 two edges after the 12th CHECK; requester 1 is served next; requester 0 then resumes.
3. **Early release.**
   - Stimulus: `req[0]` drops in the DELIVER cycle of word 3 while `req[1]` is high.
   - Required: `word_cnt` reaches 3 only; requester 1 is granted 2 edges later; no 4th word is delivered to requester 0.
4. **Timeout.**
   - Stimulus: `TIMEOUT` = 8; `src_ready` held low.
   - Required: after 8 FETCH cycles, `timeout_err` = 1 (sticky), `src_request` = 0, IDLE.
   - Required: a later request is still served; `timeout_err` stays 1 until `rst`.
5. **Reset mid-FETCH.**
   - Stimulus: `rst` pulsed during FETCH; `src_ready` arrives on the following cycle.
   - Required: all outputs 0 at the edge after reset; the late word is ignored; no `req_ready` pulse.
6. **Spurious TRNG pulse.**
   - Stimulus: `src_ready` with `src_data` = 0xDEADBEEF while IDLE, then normal traffic.
   - Required: no `req_ready`; `req_data` unchanged until the first real word.

Source files
------------

// File: rtl/trng_arbiter.sv
// Round-robin arbiter sharing one TRNG word source between NUM_REQ consumers,
// with a burst lock so each owner's multi-word acquisition stays contiguous.
module trng_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 12,
    parameter int TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0] grant,
    output logic               src_request,
    input  logic               src_ready,
    input  logic [DATA_W-1:0]  src_data,
    output logic               busy,
    output logic               timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DELIVER, CHECK} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  owner_oh;
    logic                others_req;
    logic                any_req;
    logic [PTR_W-1:0]    pick;
    logic [PTR_W-1:0]    cand;
    int                  idx;

    assign owner_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign others_req = |(req & ~owner_oh);

    // Scan downward so the candidate closest to ptr+1 is the last (winning) assignment.
    always_comb begin
        pick    = ptr_q;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx  = (int'(ptr_q) + i) % NUM_REQ;
            cand = PTR_W'(idx);
            if (req[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        word_cnt_d = word_cnt_q;
        to_cnt_d   = '0;
        data_d     = data_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d    = pick;
                    word_cnt_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (src_ready) begin
                    data_d     = src_data;
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = DELIVER;
                end else if (TIMEOUT != 0) begin
                    if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        ptr_d   = owner_q;
                        state_d = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            DELIVER: state_d = CHECK;
            CHECK: begin
                if (!req[owner_q] ||
                    ((word_cnt_q == CNT_W'(BURST_MAX)) && others_req)) begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end else begin
                    // Uncontested owner keeps the grant; restart its burst window.
                    if (word_cnt_q == CNT_W'(BURST_MAX)) word_cnt_d = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            owner_q    <= '0;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            word_cnt_q <= word_cnt_d;
            to_cnt_q   <= to_cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    assign grant       = (state_q == IDLE) ? '0 : owner_oh;
    assign req_ready   = (state_q == DELIVER) ? owner_oh : '0;
    assign src_request = (state_q == FETCH);
    assign busy        = (state_q != IDLE);
    assign req_data    = data_q;
    assign timeout_err = err_q;

endmodule
